inst_prefetch: RTL

- Sits directly upstream of the core's instruction port, between the core and a variable-latency instruction memory bus.
- Sequentially prefetches 32-bit instructions into a small FIFO tagged with their addresses.
- Each cycle it serves the instruction at the core's current PC when that PC matches the FIFO head.
- Any PC mismatch (jump or branch) flushes the FIFO and restarts fetching at the new PC.

---
 rtl/inst_prefetch.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/inst_prefetch.sv
// Instruction prefetch buffer: sequentially fetches 32-bit words into an
// address-tagged FIFO and serves the core PC from the FIFO head.
module inst_prefetch #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] core_addr_i,
    input  logic        core_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic        inst_valid_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Handshakes: mem_req_o is a level held from issue until the single
    // mem_rvalid_i pulse, with mem_addr_o stable throughout; on the core side
    // an instruction transfers on a cycle where inst_valid_o && core_ready_i.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   fa_q, fa_d;
    logic [31:0]   req_addr_q, req_addr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   tag_q  [DEPTH];
    logic [31:0]   data_q [DEPTH];

    logic          empty;
    logic [31:0]   head_tag;
    logic [31:0]   head_data;
    logic [31:0]   exp_addr;
    logic          redirect;
    logic          pop;
    logic          push;
    logic          flush;

    always_comb begin
        empty     = (count_q == '0);
        head_tag  = tag_q[rd_ptr_q];
        head_data = data_q[rd_ptr_q];
        // The address the core should ask for next if it runs sequentially.
        if (!empty) begin
            exp_addr = head_tag;
        end else if (state_q == ST_REQ) begin
            exp_addr = req_addr_q;
        end else begin
            exp_addr = fa_q;
        end
        redirect     = (core_addr_i != exp_addr);
        inst_valid_o = !empty && (head_tag == core_addr_i);
        inst_o       = inst_valid_o ? head_data : NOP_INST;
        inst_addr_o  = inst_valid_o ? head_tag : core_addr_i;
        pop          = inst_valid_o && core_ready_i;
        mem_req_o    = (state_q != ST_IDLE);
        mem_addr_o   = req_addr_q;
    end

    always_comb begin
        state_d    = state_q;
        fa_d       = fa_q;
        req_addr_d = req_addr_q;
        push       = 1'b0;
        flush      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (redirect) begin
                    fa_d  = core_addr_i;
                    flush = 1'b1;
                end else if (count_q < FULL_CNT) begin
                    req_addr_d = fa_q;
                    fa_d       = fa_q + 32'd4;
                    state_d    = ST_REQ;
                end
            end
            ST_REQ: begin
                if (redirect) begin
                    fa_d    = core_addr_i;
                    flush   = 1'b1;
                    state_d = mem_rvalid_i ? ST_IDLE : ST_DROP;
                end else if (mem_rvalid_i) begin
                    push    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_DROP: begin
                // The stale bus request must still complete before reissuing.
                if (redirect) begin
                    fa_d = core_addr_i;
                end
                if (mem_rvalid_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            fa_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fa_q       <= fa_d;
            req_addr_q <= req_addr_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Entry storage needs no reset: count_q gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_q[wr_ptr_q]  <= req_addr_q;
            data_q[wr_ptr_q] <= mem_rdata_i;
        end
    end

endmodule
